// File: rtl/pwm_spi_config_ctrl_pkg.sv
// Shared definitions for the PWM SPI configuration controller.
// Holds the frame geometry, the register map and the frame-tracking FSM state type.
package pwm_spi_config_ctrl_pkg;

   localparam int unsigned FRAME_BITS_DFLT = 16;
   // R/W bit plus 7 address bits
   localparam int unsigned HDR_BITS        = 8;
   localparam int unsigned NUM_OUT_REGS    = 5;

   localparam int unsigned ADDR_EN_OUT_LO  = 0;
   localparam int unsigned ADDR_EN_OUT_HI  = 1;
   localparam int unsigned ADDR_EN_PWM_LO  = 2;
   localparam int unsigned ADDR_EN_PWM_HI  = 3;
   localparam int unsigned ADDR_DUTY       = 4;

   typedef enum logic [1:0] {
      StWaitIdle,
      StIdle,
      StShift,
      StCommit
   } state_e;

endpackage

// File: rtl/pwm_spi_config_ctrl_sync.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser for an asynchronous input, followed by one
// edge-detect flop. The rise/fall pulses are registered so that they line up with level_o.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   d_i       asynchronous input
//   level_o   synchronised level
//   rise_o    one-clk pulse on a synchronised 0->1 transition
//   fall_o    one-clk pulse on a synchronised 1->0 transition
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_spi_config_ctrl.sv
// pwm_spi_config_ctrl: SPI-slave (mode 0) owning the PWM peripheral's configuration registers.
// Frames are 1 R/W bit + 7 address bits + 8 data bits, MSB first. Writes commit atomically one
// cycle after chip-select release; reads stream the addressed register out on cipo during the
// second byte.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   sclk, ncs, copi      SPI pins from the host (asynchronous)
//   cipo, cipo_oe        SPI readback data and its output enable
//   en_reg_* / pwm_duty_cycle  register outputs 0x00..0x04
//   cfg_update           one-clk pulse per committed write
//   frame_err            one-clk pulse per frame with a bit count other than FRAME_BITS
module pwm_spi_config_ctrl
   import pwm_spi_config_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_REGS    = 5,
   parameter int unsigned FRAME_BITS  = FRAME_BITS_DFLT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic       cipo,
   output logic       cipo_oe,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       cfg_update,
   output logic       frame_err
);

   localparam int unsigned      CNT_W     = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(HDR_BITS);
   localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(SYNC_STAGES);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic ncs_lvl, ncs_rise, ncs_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sclk),
      .level_o (sclk_lvl_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk     (clk),
      .rst     (rst),
      .d_i     (ncs),
      .level_o (ncs_lvl),
      .rise_o  (ncs_rise),
      .fall_o  (ncs_fall)
   );

   logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
   logic                   copi_s;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]  sr_q, sr_d;
   logic [7:0]             shadow_q, shadow_d;
   logic                   oe_q, oe_d;
   logic [7:0]             regs_q [NUM_OUT_REGS];
   logic [7:0]             regs_d [NUM_OUT_REGS];
   logic                   cfg_update_q, cfg_update_d;
   logic                   frame_err_q, frame_err_d;

   logic                   fr_rw;
   logic [6:0]             fr_addr, rd_addr;

   assign copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
   assign copi_s      = copi_sync_q[SYNC_STAGES-1];

   assign fr_rw   = sr_q[FRAME_BITS-1];
   assign fr_addr = sr_q[FRAME_BITS-2 -: 7];
   // Address as it will stand once the bit now arriving completes the header
   assign rd_addr = {sr_q[5:0], copi_s};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      shadow_d     = shadow_q;
      oe_d         = oe_q;
      regs_d       = regs_q;
      cfg_update_d = 1'b0;
      frame_err_d  = 1'b0;

      case (state_q)
         StWaitIdle: begin
            // The counter doubles as a flush timer: the ncs synchroniser resets to "high", so
            // its level is trusted only once the pin value has propagated through it.
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_q > CNT_FLUSH && ncs_lvl) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StIdle: begin
            if (ncs_fall) begin
               state_d = StShift;
               cnt_d   = '0;
               sr_d    = '0;
            end
         end
         StShift: begin
            if (ncs_rise) begin
               // Also swallows an sclk edge detected in this same cycle
               state_d  = StCommit;
               oe_d     = 1'b0;
               shadow_d = '0;
            end else if (!ncs_lvl) begin
               if (sclk_rise) begin
                  sr_d = {sr_q[FRAME_BITS-2:0], copi_s};
                  if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_HDR - 1'b1 && !sr_q[6]) begin
                     oe_d     = 1'b1;
                     shadow_d = '0;
                     for (int i = 0; i < int'(NUM_OUT_REGS); i++) begin
                        if (i < int'(NUM_REGS) && rd_addr == 7'(i)) shadow_d = regs_q[i];
                     end
                  end
               end else if (sclk_fall && oe_q && cnt_q > CNT_HDR) begin
                  // The falling edge right after the header is skipped so the MSB is
                  // still on cipo at the next rising edge.
                  shadow_d = {shadow_q[6:0], 1'b0};
               end
            end
         end
         StCommit: begin
            state_d = StIdle;
            if (cnt_q == CNT_FULL) begin
               if (fr_rw) begin
                  for (int i = 0; i < int'(NUM_OUT_REGS); i++) begin
                     if (i < int'(NUM_REGS) && fr_addr == 7'(i)) begin
                        regs_d[i]    = sr_q[7:0];
                        cfg_update_d = 1'b1;
                     end
                  end
               end
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         copi_sync_q  <= '0;
         state_q      <= StWaitIdle;
         cnt_q        <= '0;
         sr_q         <= '0;
         shadow_q     <= '0;
         oe_q         <= 1'b0;
         regs_q       <= '{default: '0};
         cfg_update_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         copi_sync_q  <= copi_sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         shadow_q     <= shadow_d;
         oe_q         <= oe_d;
         regs_q       <= regs_d;
         cfg_update_q <= cfg_update_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign cipo            = oe_q & shadow_q[7];
   assign cipo_oe         = oe_q;
   assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = regs_q[ADDR_DUTY];
   assign cfg_update      = cfg_update_q;
   assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_pwm_spi_config_ctrl.sv
// Directed bench for pwm_spi_config_ctrl: SPI mode-0 host model driving hand-built frames.
module tb_pwm_spi_config_ctrl;

   localparam int HALF = 5;  // sclk half period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       ncs = 1'b1;
   logic       copi = 1'b0;
   logic       cipo, cipo_oe, cfg_update, frame_err;
   logic [7:0] o70, o158, p70, p158, duty;

   int         n_checks = 0;
   int         n_pass = 0;
   int         n_fail = 0;
   int         cfg_cnt = 0;
   int         err_cnt = 0;
   int         c_cfg, c_err;
   logic       oe_seen;
   logic [31:0] rx;

   pwm_spi_config_ctrl #(.SYNC_STAGES(2), .NUM_REGS(5), .FRAME_BITS(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .sclk            (sclk),
      .ncs             (ncs),
      .copi            (copi),
      .cipo            (cipo),
      .cipo_oe         (cipo_oe),
      .en_reg_out_7_0  (o70),
      .en_reg_out_15_8 (o158),
      .en_reg_pwm_7_0  (p70),
      .en_reg_pwm_15_8 (p158),
      .pwm_duty_cycle  (duty),
      .cfg_update      (cfg_update),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_update === 1'b1) cfg_cnt <= cfg_cnt + 1;
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // exp packs registers 0x00..0x04 from the top byte down
   task automatic check_regs(input string tag, input logic [39:0] exp);
      chk({tag, "_out_7_0"},   32'(o70),  32'(exp[39:32]));
      chk({tag, "_out_15_8"},  32'(o158), 32'(exp[31:24]));
      chk({tag, "_pwm_7_0"},   32'(p70),  32'(exp[23:16]));
      chk({tag, "_pwm_15_8"},  32'(p158), 32'(exp[15:8]));
      chk({tag, "_duty"},      32'(duty), 32'(exp[7:0]));
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame();
      oe_seen = 1'b0;
      ncs = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         copi = bits[n-1-i];
         wait_clk(HALF);
         r[n-1-i] = cipo;
         oe_seen = oe_seen | cipo_oe;
         sclk = 1'b1;
         wait_clk(HALF);
         oe_seen = oe_seen | cipo_oe;
         sclk = 1'b0;
      end
   endtask

   task automatic end_frame();
      wait_clk(HALF);
      ncs = 1'b1;
      copi = 1'b0;
      wait_clk(12);
   endtask

   task automatic frame(input logic [31:0] bits, input int n);
      start_frame();
      shift_bits(bits, n, rx);
      end_frame();
   endtask

   initial begin
      // Reset state
      wait_clk(4);
      rst = 1'b0;
      wait_clk(1);
      check_regs("rst", 40'h00_00_00_00_00);
      chk("rst_cipo", 32'(cipo), 32'h0);
      chk("rst_cipo_oe", 32'(cipo_oe), 32'h0);
      chk("rst_cfg_update", 32'(cfg_update), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      wait_clk(10);

      // Write addr 1 <- 0xFF with exact commit latency (SYNC_STAGES+2 = 4)
      c_cfg = cfg_cnt;
      start_frame();
      shift_bits(32'h81FF, 16, rx);
      wait_clk(HALF);
      ncs = 1'b1;
      wait_clk(4);
      chk("lat_hold", 32'(o158), 32'h00);
      chk("lat_no_pulse_yet", 32'(cfg_update), 32'h0);
      wait_clk(1);
      chk("lat_update", 32'(o158), 32'hFF);
      chk("cfg_pulse_hi", 32'(cfg_update), 32'h1);
      wait_clk(1);
      chk("cfg_pulse_lo", 32'(cfg_update), 32'h0);
      wait_clk(10);
      check_regs("w1", 40'h00_FF_00_00_00);
      chk("w1_cfg_count", 32'(cfg_cnt - c_cfg), 32'd1);
      chk("w1_no_oe", 32'(oe_seen), 32'h0);

      // Write duty <- 0x80, then read it back
      frame(32'h8480, 16);
      chk("w4_no_oe", 32'(oe_seen), 32'h0);
      c_cfg = cfg_cnt;
      frame(32'h0400, 16);
      chk("rd4_data", 32'(rx[7:0]), 32'h80);
      chk("rd4_hdr_cipo", 32'(rx[15:8]), 32'h00);
      chk("rd4_oe_seen", 32'(oe_seen), 32'h1);
      chk("rd4_oe_after", 32'(cipo_oe), 32'h0);
      chk("rd4_cipo_after", 32'(cipo), 32'h0);
      chk("rd4_no_cfg", 32'(cfg_cnt - c_cfg), 32'd0);
      check_regs("rd4", 40'h00_FF_00_00_80);

      // Short and long frames
      c_cfg = cfg_cnt;
      c_err = err_cnt;
      frame(32'h413F, 15);
      chk("short_err", 32'(err_cnt - c_err), 32'd1);
      frame(32'h104FF, 17);
      chk("long_err", 32'(err_cnt - c_err), 32'd2);
      chk("bad_no_cfg", 32'(cfg_cnt - c_cfg), 32'd0);
      check_regs("bad", 40'h00_FF_00_00_80);

      // Out-of-range address write and read
      c_err = err_cnt;
      frame(32'h85AA, 16);
      check_regs("oor_w", 40'h00_FF_00_00_80);
      chk("oor_no_cfg", 32'(cfg_cnt - c_cfg), 32'd0);
      chk("oor_no_err", 32'(err_cnt - c_err), 32'd0);
      frame(32'h0500, 16);
      chk("oor_rd_data", 32'(rx[7:0]), 32'h00);
      chk("oor_rd_oe", 32'(oe_seen), 32'h1);

      // Reset in the middle of a write frame
      c_cfg = cfg_cnt;
      c_err = err_cnt;
      start_frame();
      shift_bits(32'h209, 10, rx);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check_regs("midrst_now", 40'h00_00_00_00_00);
      shift_bits(32'h15, 6, rx);
      end_frame();
      check_regs("midrst_end", 40'h00_00_00_00_00);
      chk("midrst_no_cfg", 32'(cfg_cnt - c_cfg), 32'd0);
      chk("midrst_no_err", 32'(err_cnt - c_err), 32'd0);
      frame(32'h803C, 16);
      check_regs("after_rst", 40'h3C_00_00_00_00);

      // sclk activity with ncs high is ignored
      c_cfg = cfg_cnt;
      c_err = err_cnt;
      for (int i = 0; i < 8; i++) begin
         copi = 1'($urandom);
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
         wait_clk(HALF);
      end
      copi = 1'b0;
      wait_clk(5);
      chk("idle_sclk_no_cfg", 32'(cfg_cnt - c_cfg), 32'd0);
      check_regs("idle_sclk", 40'h3C_00_00_00_00);
      frame(32'h835A, 16);
      check_regs("w3", 40'h3C_00_00_5A_00);
      chk("w3_cfg_count", 32'(cfg_cnt - c_cfg), 32'd1);
      chk("w3_no_err", 32'(err_cnt - c_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pwm_spi_config_ctrl.md
Name: pwm_spi_config_ctrl

Overview:
SPI-slave configuration controller that owns the PWM peripheral's control registers: output enables [15:0], PWM enables [15:0] and the 8-bit duty cycle.
- Decodes 16-bit SPI frames from the external host and commits writes atomically at frame end.
- Serves register readback.
- Sits between the top-level SPI pins and pwm_peripheral; its register outputs drive pwm_peripheral's configuration inputs directly.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk/ncs/copi (min 2)
NUM_REGS, 5, number of implemented registers, addresses 0..NUM_REGS-1
FRAME_BITS, 16, bits per frame: 1 R/W + 7 address + 8 data

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
sclk  in  1  SPI clock, mode 0, asynchronous to clk
ncs  in  1  SPI chip select, active-low, asynchronous
copi  in  1  SPI host-to-peripheral data
cipo  out  1  SPI peripheral-to-host data
cipo_oe  out  1  output enable for cipo
en_reg_out_7_0  out  8  register 0x00
en_reg_out_15_8  out  8  register 0x01
en_reg_pwm_7_0  out  8  register 0x02
en_reg_pwm_15_8  out  8  register 0x03
pwm_duty_cycle  out  8  register 0x04
cfg_update  out  1  one-clk pulse on every committed write
frame_err  out  1  one-clk pulse on a malformed frame

Behaviour:
- Reset (rst high at a clk edge): all five registers = 0x00; cipo = 0, cipo_oe = 0; cfg_update = 0, frame_err = 0; bit counter = 0; FSM = WAIT_IDLE; synchronisers cleared to sclk=0, ncs=1, copi=0.
- Synchronisation: sclk, ncs and copi each pass through SYNC_STAGES flops, plus one extra flop for edge detection. Requirement: sclk period ≥ 8 clk periods.
- FSM states:
  - WAIT_IDLE → IDLE when synced ncs = 1. This covers reset released mid-frame: the partial frame is discarded.
  - IDLE → SHIFT on synced ncs falling edge; clear counter and shift register.
  - SHIFT:
    - On each synced sclk rising edge with ncs low: shift copi in MSB first; counter increments and saturates at FRAME_BITS+1.
    - On ncs rising edge: go to COMMIT.
    - sclk edges while ncs is high are ignored in every state.
  - COMMIT (one cycle), then IDLE:
    - Write: counter == 16, bit15 = 1, addr < NUM_REGS → reg[addr] ← data; pulse cfg_update.
    - Write with addr ≥ NUM_REGS → silently ignored; no pulse.
    - Read: counter == 16, bit15 = 0 → no register change; no pulse.
    - Counter ≠ 16 (short or long frame) → no write; pulse frame_err.
- Commit latency: register outputs and cfg_update change on the clk edge SYNC_STAGES+2 cycles after the first clk edge that samples ncs high at the pin. All five registers are never partially updated.
- Readback:
  - Trigger: in SHIFT, when the counter reaches 8 with bit7 of the shift register = 0 (read).
  - Load an 8-bit shadow with reg[addr], or 0x00 if addr ≥ NUM_REGS.
  - Assert cipo_oe and drive the shadow MSB onto cipo.
  - Each subsequent synced sclk falling edge shifts the next bit out.
  - cipo_oe deasserts and cipo returns to 0 in the cycle ncs rising is detected.
  - A write frame never asserts cipo_oe.
- Simultaneous events: an ncs rising edge detected in the same cycle as an sclk rising edge ignores the sclk edge.
- rst asserted mid-frame: immediate reset values, then WAIT_IDLE.
- Undriven bits: unused addresses return 0x00.

Decomposition:
- Shared package: register address constants (ADDR_EN_OUT_LO = 0x00 … ADDR_DUTY = 0x04), FRAME_BITS, and the FSM state enum {WAIT_IDLE, IDLE, SHIFT, COMMIT}.
- One natural sub-module: spi_sync_edge, an N-stage synchroniser with rise/fall pulse outputs, instantiated for sclk and ncs. copi uses the plain synchroniser path only.

Test Plan:
- Write 0x81,0xFF (addr 1 ← 0xFF) → en_reg_out_15_8 = 0xFF exactly SYNC_STAGES+2 clks after ncs high; one cfg_update pulse; other registers remain 0x00.
- Write addr 4 ← 0x80, then read addr 4 (frame 0x04,0x00) → cipo shifts 1000_0000 on bits 8–15; cipo_oe high only during the read frame; duty unchanged at 0x80.
- 15-bit frame 0x82,0x7F → no register change, frame_err pulse; 17-bit frame → same response.
- Write to addr 0x05 with 0xAA → all registers unchanged, no cfg_update, no frame_err; read of addr 0x05 returns 0x00.
- Assert rst for 1 clk after 10 bits of a write with ncs still low, then finish the frame → registers remain 0x00, no pulses. The next full frame 0x80,0x3C sets en_reg_out_7_0 = 0x3C.
- sclk toggling with ncs high, then a normal write 0x83,0x5A → only en_reg_pwm_15_8 = 0x5A; the idle clocks have no effect.
